// File: rtl/pc_sequencer.sv
// Run-control and next-address stage feeding the i281 program-counter register.
// Chooses execute cycles (free-run, single-step or halt) and computes the next PC.
module pc_sequencer #(
    parameter int unsigned N        = 16,
    parameter int unsigned PRESCALE = 1,
    parameter int unsigned OFF_W    = 8
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt_req,
    input  logic             branch_taken,
    input  logic [OFF_W-1:0] branch_offset,
    input  logic [N-1:0]     pc_q,
    output logic [N-1:0]     next_pc,
    output logic             pc_load,
    output logic             exec_en,
    output logic [1:0]       state
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10,
        STEP = 2'b11
    } state_t;

    state_t           st;
    logic [CNT_W-1:0] count;
    logic             sync1, sync2, step_hist;
    logic             step_edge;
    logic             tick;
    logic [N-1:0]     off_ext;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            step_hist <= 1'b0;
        end else begin
            sync1     <= step_btn;
            sync2     <= sync1;
            step_hist <= sync2;
        end
    end

    assign step_edge = sync2 & ~step_hist;
    assign tick      = (st == RUN) && (count == CNT_LAST);

    // A run_sw drop suppresses a coinciding tick so leaving RUN never executes.
    assign exec_en = ((st == RUN) && tick && run_sw) || (st == STEP);
    assign pc_load = exec_en & ~halt_req;
    assign state   = st;

    assign off_ext = {{(N - OFF_W){branch_offset[OFF_W-1]}}, branch_offset};
    assign next_pc = pc_q + N'(1) + (branch_taken ? off_ext : '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st    <= IDLE;
            count <= '0;
        end else begin
            unique case (st)
                IDLE: begin
                    count <= '0;
                    if (run_sw) begin
                        st <= RUN;
                    end else if (step_edge) begin
                        st <= STEP;
                    end
                end
                RUN: begin
                    if (!run_sw) begin
                        st    <= IDLE;
                        count <= '0;
                    end else if (exec_en && halt_req) begin
                        st    <= HALT;
                        count <= '0;
                    end else begin
                        count <= tick ? '0 : count + CNT_W'(1);
                    end
                end
                STEP: begin
                    count <= '0;
                    st    <= halt_req ? HALT : IDLE;
                end
                HALT: begin
                    count <= '0;
                    if (!run_sw) begin
                        st <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
